uart_tx_fifo: RTL

Byte buffer and launch sequencer upstream of the UART transmit controller. Accepts bytes from the host side through a write-enable interface and stores them in a circular FIFO. Drains them one at a time to the transmitter, presenting a stable byte on tx_data with a one-cycle tx_start strobe. Stays in step with the transmitter's busy indication so no byte is launched while a frame is in flight.

---
 rtl/uart_tx_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte buffer and launch sequencer in front of the UART transmit controller.
// Host bytes are queued in a circular FIFO and handed to the transmitter one
// at a time. Each byte is presented on tx_data together with a one-cycle
// tx_start strobe. The sequencer then follows tx_busy so that no new byte is
// launched while a frame is in flight.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   wr_en     in   host write request
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds DEPTH entries
//   empty     out  FIFO holds no entries
//   count     out  occupancy, 0..DEPTH
//   overflow  out  sticky: a write was dropped because the FIFO was full
//   tx_busy   in   transmitter is sending a frame
//   tx_data   out  byte for the transmitter; held until the next launch
//   tx_start  out  one-cycle launch strobe
//
// Sequencer states
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | ready; pops a byte when one is queued and tx_busy is low
//   ST_LAUNCH  | tx_start is high in this cycle
//   ST_WAIT_BUSY | waiting for tx_busy to rise; gives up after BUSY_TIMEOUT
//   ST_WAIT_DONE | frame in flight; waiting for tx_busy to fall
module uart_tx_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_start
);

    localparam int TMO_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(BUSY_TIMEOUT);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [ADDR_WIDTH:0]     count_q,    count_d;
    logic                    overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0]   tx_data_q,  tx_data_d;
    logic                    tx_start_q, tx_start_d;
    logic [TMO_W-1:0]        tmo_cnt_q,  tmo_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

    logic wr_acc;
    logic pop;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

    // Acceptance looks only at the registered full flag, so a pop in the
    // same cycle never makes room for a write to a full FIFO.
    assign wr_acc = wr_en && !full;
    assign pop    = (state_q == ST_IDLE) && !empty && !tx_busy;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        state_d    = state_q;

        if (wr_acc) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + ADDR_WIDTH'(1);
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_start_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A transmitter that never raises busy is assumed to have
                // taken the byte; the timeout lets the queue keep draining.
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
